adder_sched: RTL and testbench
==============================

Name: adder_sched

Overview:
- Round-robin scheduler that shares one accumulator (`adder`, instantiated internally) among NUM_REQ requesters.
- Each requester asks for a job of req_len addends. The scheduler grants one requester at a time and clears the accumulator.
- It streams that requester's addends into the accumulator through a valid/ready handshake, then returns the final sum with a done pulse.
- It sits between the processing-element front ends and the shared accumulation datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, addend/sum width, passed to `adder`
- CNT_WIDTH, 8, width of per-job length field

Ports:
- Clk  in  1  clock, all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  job request per requester (level)
- req_len  in  NUM_REQ*CNT_WIDTH  job length per requester, slice i = [i*CNT_WIDTH +: CNT_WIDTH]
- req_data  in  NUM_REQ*DATA_WIDTH  addend per requester, same slicing
- req_valid  in  NUM_REQ  addend valid per requester
- req_ready  out  NUM_REQ  addend accepted this cycle (only granted index may be 1)
- gnt  out  NUM_REQ  one-hot grant, registered
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, result valid
- done_id  out  $clog2(NUM_REQ)  index of the finished requester
- result  out  DATA_WIDTH  final accumulated sum, held until next done

Behaviour:
- Reset (sync, Rst=1 at edge):
  - state=IDLE; gnt=0, done=0, done_id=0, result=0, busy=0, req_ready=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
  - The `adder` is also reset: adder reset = Rst | clr.
- States IDLE, CLEAR, ACCUM, DONE:
  - IDLE:
    - If any req[i]=1, select the first set bit searching from last+1 upward with wrap.
    - Latch id and cnt=req_len[id]; gnt<=onehot(id); last<=id; go to CLEAR.
    - Otherwise stay.
  - CLEAR: clr=1 for exactly one cycle, zeroing the accumulator at the next edge. Go to ACCUM if cnt!=0, else DONE.
  - ACCUM:
    - req_ready[id]=1 combinationally, all other ready bits 0.
    - Drive adder Add=req_valid[id], addend=req_data slice id.
    - Each beat (valid&ready at an edge) decrements cnt.
    - The beat taken when cnt==1 goes to DONE; no further ready.
    - Idle (valid=0) cycles are allowed with no timeout.
  - DONE:
    - Accumulator sum is final in this cycle.
    - At the edge: result<=sum, done<=1, done_id<=id, gnt<=0; go to IDLE.
    - done falls automatically the following edge.
- Latency: grant registered 1 edge after req seen in IDLE; first beat can be accepted at the 3rd edge after req seen. done is high the cycle after the edge following the final beat.
- A new grant may be issued in the same cycle done is high, since IDLE arbitrates then.
- Arithmetic: sum wraps modulo 2^DATA_WIDTH; no overflow flag.
- req_len=0: job runs CLEAR→DONE and reports result=0.
- req deasserted mid-job: ignored; the job ends only after req_len beats.
- req_valid on non-granted requesters: ignored, their ready stays 0.
- req_len is sampled only at grant; later changes are ignored.
- Rst mid-job: immediate return to reset values; the partial job is lost and no done is issued.

Decomposition:
- Shared package/definitions header holds:
  - state encoding constants (IDLE=0, CLEAR=1, ACCUM=2, DONE=3)
  - the clkPeriod define used by benches
- Sub-module: existing `adder` (DATA_WIDTH passed through), instantiated once.
- Optional helper `rr_pick`: combinational round-robin selector taking req and last, producing an index and a found flag.

Test Plan:
- Single job: Rst, then req[0]=1, len=4, data 1,2,3,4 valid every cycle → gnt=0001; 4 readies; done once with result=10, done_id=0.
- Round-robin: req=1111 held, each len=1, data=i+5 → grants in order 0,1,2,3,0; results 5,6,7,8; no requester is granted twice in a row while others wait.
- Backpressure gaps: req[2], len=3, valid pattern 1,0,0,1,0,1 with data 7,x,x,8,x,9 → exactly 3 beats; result=24; done 2 cycles after the third beat edge.
- Zero length and wrap:
  - req[1] len=0 → done with result=0 after CLEAR.
  - Then len=2, data FFFFFFFF and 00000003 → result=00000002.
- Accumulator clear between jobs: job A sum=100, then job B len=1, data=1 → result=1, not 101.
- Reset mid-job: Rst high during the 2nd of 5 beats → next cycle gnt=0, busy=0, done never pulses; a subsequent req[3] job completes correctly.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared definitions for the round-robin accumulator scheduler: FSM states,
// default sizing and the lowest-set-bit picker used by the arbiter.
`ifndef clkPeriod
`define clkPeriod 10
`endif

package adder_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 8;

    // Returns {found, index} of the lowest set bit of an up-to-8-bit vector.
    function automatic logic [3:0] first_set8(input logic [7:0] vec);
        logic [3:0] pick;
        pick = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            pick = vec[i] ? {1'b1, 3'(i)} : pick;
        end
        return pick;
    endfunction

endpackage

// File: rtl/adder_sched_if.sv
// Requester-side bundle of the scheduler: job requests, addend handshakes,
// grant/status and the completion report.
interface adder_sched_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*CNT_WIDTH-1:0]  req_len;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            gnt;
    logic                          busy;
    logic                          done;
    logic [ID_W-1:0]               done_id;
    logic [DATA_WIDTH-1:0]         result;

    modport master (
        output req, req_len, req_data, req_valid,
        input  req_ready, gnt, busy, done, done_id, result
    );

    modport slave (
        input  req, req_len, req_data, req_valid,
        output req_ready, gnt, busy, done, done_id, result
    );
endinterface

// File: rtl/adder.sv
// Shared accumulation datapath: a register that adds the addend whenever Add
// is high and wraps modulo 2^DATA_WIDTH.
module adder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Add,
    input  logic [DATA_WIDTH-1:0] addend,
    output logic [DATA_WIDTH-1:0] sum
);

    // Accumulator register, cleared by reset or by the scheduler's clear.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sum <= {DATA_WIDTH{1'b0}};
        end else if (Add) begin
            sum <= sum + addend;
        end else begin
            sum <= sum;
        end
    end

endmodule

// File: rtl/adder_sched.sv
// Round-robin scheduler that lends the single shared accumulator to one
// requester at a time and reports each finished job's sum.
module adder_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input logic          Clk,
    input logic          Rst,
    adder_sched_if.slave bus
);
    import adder_sched_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    state_e                state_r, state_s;
    logic [ID_W-1:0]       id_r, last_r, done_id_r, pick_id_s;
    logic [CNT_WIDTH-1:0]  cnt_r, pick_len_s;
    logic [NUM_REQ-1:0]    gnt_r, ready_s, hi_s, lo_s;
    logic                  done_r, clr_s, add_s, pick_found_s;
    logic [3:0]            hi_pick_s, lo_pick_s;
    logic [DATA_WIDTH-1:0] result_r, addend_s, sum_s;

    // Round-robin pick: requesters above last take priority over those at or below it.
    always_comb begin
        hi_s = {NUM_REQ{1'b0}};
        lo_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_s[i] = bus.req[i] & (ID_W'(i) > last_r);
            lo_s[i] = bus.req[i] & ~(ID_W'(i) > last_r);
        end
        hi_pick_s    = first_set8(8'(hi_s));
        lo_pick_s    = first_set8(8'(lo_s));
        pick_found_s = hi_pick_s[3] | lo_pick_s[3];
        pick_id_s    = hi_pick_s[3] ? ID_W'(hi_pick_s[2:0]) : ID_W'(lo_pick_s[2:0]);
    end

    assign pick_len_s = bus.req_len[pick_id_s*CNT_WIDTH +: CNT_WIDTH];
    assign addend_s   = bus.req_data[id_r*DATA_WIDTH +: DATA_WIDTH];

    // Next-state and datapath controls for the job sequence.
    always_comb begin
        state_s = state_r;
        clr_s   = 1'b0;
        add_s   = 1'b0;
        ready_s = {NUM_REQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (pick_found_s) state_s = CLEAR;
                else              state_s = IDLE;
            end
            CLEAR: begin
                clr_s = 1'b1;
                if (cnt_r != {CNT_WIDTH{1'b0}}) state_s = ACCUM;
                else                            state_s = DONE;
            end
            ACCUM: begin
                ready_s = NUM_REQ'(1'b1) << id_r;
                add_s   = bus.req_valid[id_r];
                if (add_s && (cnt_r == CNT_WIDTH'(1'b1))) state_s = DONE;
                else                                      state_s = ACCUM;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register plus job bookkeeping and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r   <= IDLE;
            id_r      <= {ID_W{1'b0}};
            last_r    <= ID_W'(NUM_REQ - 1);
            cnt_r     <= {CNT_WIDTH{1'b0}};
            gnt_r     <= {NUM_REQ{1'b0}};
            done_r    <= 1'b0;
            done_id_r <= {ID_W{1'b0}};
            result_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        id_r   <= pick_id_s;
                        last_r <= pick_id_s;
                        cnt_r  <= pick_len_s;
                        gnt_r  <= NUM_REQ'(1'b1) << pick_id_s;
                    end
                end
                ACCUM: begin
                    if (add_s) cnt_r <= cnt_r - CNT_WIDTH'(1'b1);
                end
                DONE: begin
                    result_r  <= sum_s;
                    done_r    <= 1'b1;
                    done_id_r <= id_r;
                    gnt_r     <= {NUM_REQ{1'b0}};
                end
                default: begin
                end
            endcase
        end
    end

    adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
        .Clk    (Clk),
        .Rst    (Rst | clr_s),
        .Add    (add_s),
        .addend (addend_s),
        .sum    (sum_s)
    );

    assign bus.req_ready = ready_s;
    assign bus.gnt       = gnt_r;
    assign bus.busy      = (state_r != IDLE);
    assign bus.done      = done_r;
    assign bus.done_id   = done_id_r;
    assign bus.result    = result_r;

endmodule

// File: tb/tb_adder_sched.sv
// Directed bench for adder_sched: expected job results come from the stimulus
// arithmetic, and a per-cycle monitor checks grant/ready/done against them.
`ifndef clkPeriod
`define clkPeriod 10
`endif

module tb_adder_sched;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int CW = 8;

    typedef struct {
        int          id;
        logic [31:0] res;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    adder_sched_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    adder_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #(`clkPeriod / 2) clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Per-cycle monitor: grant/ready legality and done reports against the expected queue.
    always @(negedge clk) begin
        exp_t e;
        chk("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'd1);
        chk("ready_outside_gnt", 64'(bus.req_ready & ~bus.gnt), 64'd0);
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done_id", 64'(bus.done_id), 64'(e.id));
                chk("result", 64'(bus.result), 64'(e.res));
            end
        end
    end

    // One job for requester id: vmask bit k says whether entry k is presented valid.
    task automatic run_job(input int id, input int len, input int n,
                           input logic [7:0] vmask, input logic [31:0] d [8]);
        logic [31:0] sum;
        int t;
        sum = 32'd0;
        for (int k = 0; k < n; k++) if (vmask[k]) sum = sum + d[k];
        exp_q.push_back('{id, sum});
        bus.req_len[id*CW +: CW] = CW'(len);
        bus.req[id] = 1'b1;
        t = 0;
        while (bus.gnt[id] !== 1'b1 && t < 20) begin tick(); t++; end
        chk("gnt_wait", 64'(bus.gnt[id]), 64'd1);
        bus.req[id] = 1'b0;
        if (n == 0) begin
            tick();
        end else begin
            t = 0;
            while (bus.req_ready[id] !== 1'b1 && t < 10) begin tick(); t++; end
            chk("ready_wait", 64'(bus.req_ready[id]), 64'd1);
            for (int k = 0; k < n; k++) begin
                bus.req_valid[id] = vmask[k];
                bus.req_data[id*DW +: DW] = d[k];
                tick();
            end
        end
        bus.req_valid[id] = 1'b0;
        chk("ready_after_last", 64'(bus.req_ready), 64'd0);
        chk("done_early", 64'(bus.done), 64'd0);
        tick();
        chk("done_latency", 64'(bus.done), 64'd1);
        chk("gnt_cleared", 64'(bus.gnt), 64'd0);
        tick();
    endtask

    initial begin
        int t;
        int ng;
        logic [NR-1:0] prev;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.req_len = '0;
        bus.req_data = '0;
        bus.req_valid = '0;
        repeat (3) tick();
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_done_id", 64'(bus.done_id), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        rst = 1'b0;

        // Round robin: all four request with len 1, data i+5; grants rotate 0,1,2,3,0.
        for (int i = 0; i < NR; i++) begin
            bus.req_len[i*CW +: CW] = 8'd1;
            bus.req_data[i*DW +: DW] = 32'(i + 5);
        end
        exp_q.push_back('{0, 32'd5});
        exp_q.push_back('{1, 32'd6});
        exp_q.push_back('{2, 32'd7});
        exp_q.push_back('{3, 32'd8});
        exp_q.push_back('{0, 32'd5});
        bus.req_valid = 4'b1111;
        bus.req = 4'b1111;
        prev = '0;
        ng = 0;
        t = 0;
        while (ng < 5 && t < 60) begin
            tick();
            t++;
            if (bus.gnt != 4'b0000 && prev == 4'b0000) begin
                chk("rr_order", 64'(bus.gnt), 64'(4'b0001 << (ng % 4)));
                ng++;
                if (ng == 5) bus.req = 4'b0000;
            end
            prev = bus.gnt;
        end
        chk("rr_grants", 64'(ng), 64'd5);
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin tick(); t++; end
        chk("rr_drain", 64'(exp_q.size()), 64'd0);
        bus.req_valid = '0;
        tick();

        // Single job with hand-timed cycles: req0, len 4, data 1..4, result 10.
        exp_q.push_back('{0, 32'd10});
        bus.req_len[0 +: CW] = 8'd4;
        bus.req[0] = 1'b1;
        tick();
        chk("t1_gnt", 64'(bus.gnt), 64'h1);
        chk("t1_busy", 64'(bus.busy), 64'd1);
        chk("t1_clear_ready", 64'(bus.req_ready), 64'd0);
        bus.req[0] = 1'b0;
        bus.req_len[0 +: CW] = 8'd9;
        tick();
        chk("t1_ready", 64'(bus.req_ready), 64'h1);
        for (int k = 1; k <= 4; k++) begin
            bus.req_valid[0] = 1'b1;
            bus.req_data[0 +: DW] = 32'(k);
            tick();
        end
        bus.req_valid[0] = 1'b0;
        chk("t1_no_ready_done", 64'(bus.req_ready), 64'd0);
        chk("t1_done_early", 64'(bus.done), 64'd0);
        tick();
        chk("t1_done", 64'(bus.done), 64'd1);
        chk("t1_result", 64'(bus.result), 64'd10);
        chk("t1_busy_idle", 64'(bus.busy), 64'd0);
        tick();
        chk("t1_done_fall", 64'(bus.done), 64'd0);
        chk("t1_result_held", 64'(bus.result), 64'd10);

        // Backpressure gaps on req2 while req0 presents valid data that must be ignored.
        bus.req_valid[0] = 1'b1;
        bus.req_data[0 +: DW] = 32'd1000;
        run_job(2, 3, 6, 8'b0010_1001, '{32'd7, 32'd0, 32'd0, 32'd8, 32'd0, 32'd9, 32'd0, 32'd0});
        bus.req_valid[0] = 1'b0;

        // Zero length, then wrap-around sum.
        run_job(1, 0, 0, 8'b0, '{default: 32'd0});
        run_job(1, 2, 2, 8'b11, '{32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});

        // Accumulator must restart from zero for each job.
        run_job(0, 2, 2, 8'b11, '{32'd60, 32'd40, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});
        run_job(3, 1, 1, 8'b1, '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});

        // Reset during the second of five beats: job lost, no done.
        bus.req_len[0 +: CW] = 8'd5;
        bus.req[0] = 1'b1;
        t = 0;
        while (bus.req_ready[0] !== 1'b1 && t < 10) begin tick(); t++; end
        chk("rm_ready_wait", 64'(bus.req_ready[0]), 64'd1);
        bus.req[0] = 1'b0;
        bus.req_valid[0] = 1'b1;
        bus.req_data[0 +: DW] = 32'd11;
        tick();
        bus.req_data[0 +: DW] = 32'd12;
        rst = 1'b1;
        tick();
        chk("rm_gnt", 64'(bus.gnt), 64'd0);
        chk("rm_busy", 64'(bus.busy), 64'd0);
        chk("rm_result", 64'(bus.result), 64'd0);
        rst = 1'b0;
        bus.req_valid[0] = 1'b0;
        repeat (4) tick();
        run_job(3, 2, 2, 8'b11, '{32'd20, 32'd22, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});

        repeat (3) tick();
        chk("pending_dones", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
